// File: rtl/cpu_pkg.sv
// Shared types for the CPU memory subsystem.
//   arb_state_e : memory arbiter state (round-robin, loader lock, forced CPU yield)
//   req_id_e    : requester identity, used for fairness history and read ownership
package cpu_pkg;

  typedef enum logic [1:0] {
    ARB_RR    = 2'd0,
    ARB_LOCK  = 2'd1,
    ARB_YIELD = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_LDR = 1'b1
  } req_id_e;

endpackage

// File: rtl/burst_limiter.sv
// Saturating beat counter for the loader burst lock.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart the count; together with inc the count restarts at 1
//   inc        : count one accepted beat (holds once MAX is reached)
//   at_max     : count has reached MAX
module burst_limiter #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic at_max
);

  logic [W-1:0] count_q;

  assign at_max = (count_q == W'(MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      // clear+inc is the lock-entry beat, which already counts as the first
      count_q <= inc ? W'(1) : '0;
    end else if (inc && !at_max) begin
      count_q <= count_q + W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port synchronous-read RAM between the CPU and the
// program loader. Round-robin between requesters; the loader may lock the RAM
// for a burst but yields to a waiting CPU after MAX_BURST beats.
// Ports:
//   clk, reset                              : clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata -> cpu_gnt        : CPU request, combinational grant
//   cpu_rvalid, cpu_rdata                   : CPU read return (1 cycle after grant)
//   ldr_req/we/addr/wdata/lock -> ldr_gnt   : loader request, combinational grant
//   ldr_rvalid, ldr_rdata                   : loader read return
//   ram_en/we/addr/wdata, ram_rdata         : RAM port
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [N-1:0] cpu_addr,
  input  logic [N-1:0] cpu_wdata,
  output logic         cpu_gnt,
  output logic         cpu_rvalid,
  output logic [N-1:0] cpu_rdata,
  input  logic         ldr_req,
  input  logic         ldr_we,
  input  logic [N-1:0] ldr_addr,
  input  logic [N-1:0] ldr_wdata,
  input  logic         ldr_lock,
  output logic         ldr_gnt,
  output logic         ldr_rvalid,
  output logic [N-1:0] ldr_rdata,
  output logic         ram_en,
  output logic         ram_we,
  output logic [N-1:0] ram_addr,
  output logic [N-1:0] ram_wdata,
  input  logic [N-1:0] ram_rdata
);

  arb_state_e arb_q, arb_d;
  req_id_e    last_q, last_d;
  req_id_e    rd_owner_q;
  logic       cpu_rvalid_q, ldr_rvalid_q;
  logic       burst_clear, burst_inc, burst_at_max;
  logic       rr_cpu, rr_ldr;

  burst_limiter #(
    .MAX (MAX_BURST),
    .W   (4)
  ) u_burst (
    .clk    (clk),
    .reset  (reset),
    .clear  (burst_clear),
    .inc    (burst_inc),
    .at_max (burst_at_max)
  );

  // Round-robin choice: on a tie the side that was not served last wins
  assign rr_cpu = cpu_req && (!ldr_req || (last_q == REQ_LDR));
  assign rr_ldr = ldr_req && !rr_cpu;

  always_comb begin
    cpu_gnt     = 1'b0;
    ldr_gnt     = 1'b0;
    arb_d       = arb_q;
    last_d      = last_q;
    burst_clear = 1'b0;
    burst_inc   = 1'b0;

    unique case (arb_q)
      ARB_RR: begin
        cpu_gnt = rr_cpu;
        ldr_gnt = rr_ldr;
        if (rr_ldr && ldr_lock) begin
          arb_d       = ARB_LOCK;
          burst_clear = 1'b1;
          burst_inc   = 1'b1;
        end
      end
      ARB_LOCK: begin
        if (!ldr_lock) begin
          cpu_gnt = rr_cpu;
          ldr_gnt = rr_ldr;
          arb_d   = ARB_RR;
        end else if (burst_at_max && cpu_req) begin
          // Nobody is granted on the hand-over cycle
          arb_d = ARB_YIELD;
        end else begin
          ldr_gnt   = ldr_req;
          burst_inc = ldr_req;
        end
      end
      ARB_YIELD: begin
        // Either the CPU beat is taken now or the CPU has withdrawn: leave in both cases
        cpu_gnt = cpu_req;
        if (ldr_lock) begin
          arb_d       = ARB_LOCK;
          burst_clear = 1'b1;
        end else begin
          arb_d = ARB_RR;
        end
      end
      default: arb_d = ARB_RR;
    endcase

    if (cpu_gnt) begin
      last_d = REQ_CPU;
    end else if (ldr_gnt) begin
      last_d = REQ_LDR;
    end
  end

  assign ram_en    = cpu_gnt | ldr_gnt;
  assign ram_we    = (cpu_gnt & cpu_we) | (ldr_gnt & ldr_we);
  assign ram_addr  = cpu_gnt ? cpu_addr  : ldr_addr;
  assign ram_wdata = cpu_gnt ? cpu_wdata : ldr_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arb_q        <= ARB_RR;
      last_q       <= REQ_LDR;
      rd_owner_q   <= REQ_CPU;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
    end else begin
      arb_q        <= arb_d;
      last_q       <= last_d;
      cpu_rvalid_q <= cpu_gnt & ~cpu_we;
      ldr_rvalid_q <= ldr_gnt & ~ldr_we;
      if (ram_en) begin
        rd_owner_q <= cpu_gnt ? REQ_CPU : REQ_LDR;
      end
    end
  end

  assign cpu_rvalid = cpu_rvalid_q && (rd_owner_q == REQ_CPU);
  assign ldr_rvalid = ldr_rvalid_q && (rd_owner_q == REQ_LDR);
  assign cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
  assign ldr_rdata  = ldr_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       ldr_req, ldr_we, ldr_lock, ldr_gnt, ldr_rvalid;
  logic [7:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic [7:0] mem [256];

  int n_assert = 0;
  int n_fail   = 0;

  mem_arbiter #(
    .N         (8),
    .MAX_BURST (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_lock   (ldr_lock),
    .ldr_gnt    (ldr_gnt),
    .ldr_rvalid (ldr_rvalid),
    .ldr_rdata  (ldr_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  // Write-first synchronous RAM
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        ram_rdata     <= ram_wdata;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[5] = 8'hA7;
    ram_rdata = '0;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0; ldr_lock = 0;
    #1;
    chk("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk("rst_ldr_gnt", ldr_gnt, 1'b0);
    chk("rst_ram_en", ram_en, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    chk("rst_ldr_rvalid", ldr_rvalid, 1'b0);
    chk8("rst_cpu_rdata", cpu_rdata, 8'h00);
    chk8("rst_ldr_rdata", ldr_rdata, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // 1: CPU read of 0x05
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h05;
    #1;
    chk("t1_cpu_gnt", cpu_gnt, 1'b1);
    chk("t1_ldr_gnt", ldr_gnt, 1'b0);
    chk("t1_ram_en", ram_en, 1'b1);
    chk("t1_ram_we", ram_we, 1'b0);
    chk8("t1_ram_addr", ram_addr, 8'h05);
    cyc();
    cpu_req = 0;
    chk("t1_cpu_rvalid", cpu_rvalid, 1'b1);
    chk8("t1_cpu_rdata", cpu_rdata, 8'hA7);
    chk("t1_ldr_rvalid", ldr_rvalid, 1'b0);
    cyc();
    chk("t1_rvalid_one_cycle", cpu_rvalid, 1'b0);
    chk8("t1_rdata_zero", cpu_rdata, 8'h00);

    // 2: reset restores CPU-first tie, then strict alternation
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h01;
    ldr_req = 1; ldr_we = 0; ldr_addr = 8'h02; ldr_lock = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t2_cpu_gnt", cpu_gnt, 1'((i % 2) == 0));
      chk("t2_ldr_gnt", ldr_gnt, 1'((i % 2) == 1));
      chk("t2_ram_en", ram_en, 1'b1);
      chk8("t2_ram_addr", ram_addr, ((i % 2) == 0) ? 8'h01 : 8'h02);
      cyc();
      chk("t2_cpu_rvalid", cpu_rvalid, 1'((i % 2) == 0));
      chk("t2_ldr_rvalid", ldr_rvalid, 1'((i % 2) == 1));
    end
    cpu_req = 0; ldr_req = 0;
    cyc();

    // 3: locked burst 0x10..0x17 with CPU waiting
    ldr_req = 1; ldr_we = 1; ldr_lock = 1; ldr_addr = 8'h10; ldr_wdata = 8'h10 ^ 8'hC3;
    #1;
    chk("t3_lock_entry_gnt", ldr_gnt, 1'b1);
    chk("t3_ram_we", ram_we, 1'b1);
    cyc();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    for (int a = 8'h11; a <= 8'h13; a++) begin
      ldr_addr = 8'(a); ldr_wdata = 8'(a) ^ 8'hC3;
      #1;
      chk("t3_ldr_gnt_a", ldr_gnt, 1'b1);
      chk("t3_cpu_blocked_a", cpu_gnt, 1'b0);
      cyc();
    end
    ldr_addr = 8'h14; ldr_wdata = 8'h14 ^ 8'hC3;
    #1;
    chk("t3_handover_ldr", ldr_gnt, 1'b0);
    chk("t3_handover_cpu", cpu_gnt, 1'b0);
    chk("t3_handover_en", ram_en, 1'b0);
    cyc();
    #1;
    chk("t3_yield_cpu_gnt", cpu_gnt, 1'b1);
    chk("t3_yield_ldr_gnt", ldr_gnt, 1'b0);
    chk8("t3_yield_addr", ram_addr, 8'h10);
    cyc();
    cpu_req = 0;
    chk("t3_cpu_rvalid", cpu_rvalid, 1'b1);
    chk8("t3_cpu_rdata", cpu_rdata, 8'hD3);
    for (int a = 8'h14; a <= 8'h17; a++) begin
      ldr_addr = 8'(a); ldr_wdata = 8'(a) ^ 8'hC3;
      #1;
      chk("t3_ldr_gnt_b", ldr_gnt, 1'b1);
      chk8("t3_wdata_b", ram_wdata, 8'(a) ^ 8'hC3);
      cyc();
    end
    ldr_req = 0; ldr_lock = 0;
    cyc();

    // 4: idle lock holds off the CPU without consuming burst
    ldr_req = 1; ldr_we = 1; ldr_lock = 1; ldr_addr = 8'h18; ldr_wdata = 8'h18 ^ 8'hC3;
    #1;
    chk("t4_lock_entry_gnt", ldr_gnt, 1'b1);
    cyc();
    ldr_req = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h18;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_idle_cpu_gnt", cpu_gnt, 1'b0);
      chk("t4_idle_ram_en", ram_en, 1'b0);
      cyc();
    end
    ldr_req = 1;
    for (int a = 8'h19; a <= 8'h1B; a++) begin
      ldr_addr = 8'(a); ldr_wdata = 8'(a) ^ 8'hC3;
      #1;
      chk("t4_ldr_gnt", ldr_gnt, 1'b1);
      chk("t4_cpu_blocked", cpu_gnt, 1'b0);
      cyc();
    end
    ldr_addr = 8'h1C;
    #1;
    chk("t4_handover_ldr", ldr_gnt, 1'b0);
    cyc();
    ldr_req = 0; ldr_lock = 0;
    #1;
    chk("t4_yield_cpu_gnt", cpu_gnt, 1'b1);
    cyc();
    cpu_req = 0;
    chk("t4_cpu_rvalid", cpu_rvalid, 1'b1);
    chk8("t4_cpu_rdata", cpu_rdata, 8'hDB);

    // 5: reset right after an accepted locked loader read
    ldr_req = 1; ldr_we = 0; ldr_lock = 1; ldr_addr = 8'h05;
    #1;
    chk("t5_ldr_gnt", ldr_gnt, 1'b1);
    cyc();
    ldr_req = 0; ldr_lock = 0;
    reset = 1'b1;
    #1;
    chk("t5_ldr_rvalid_dropped", ldr_rvalid, 1'b0);
    chk8("t5_ldr_rdata_zero", ldr_rdata, 8'h00);
    cyc();
    chk("t5_no_rvalid_after", ldr_rvalid, 1'b0);
    reset = 1'b0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h05;
    ldr_req = 1; ldr_we = 0; ldr_addr = 8'h06; ldr_lock = 1;
    #1;
    chk("t5_tie_cpu_gnt", cpu_gnt, 1'b1);
    chk("t5_tie_ldr_gnt", ldr_gnt, 1'b0);
    cyc();
    cpu_req = 0; ldr_req = 0; ldr_lock = 0;
    chk8("t5_cpu_rdata", cpu_rdata, 8'hA7);
    cyc();

    // 6: loader write then CPU read of the same address
    ldr_req = 1; ldr_we = 1; ldr_addr = 8'h20; ldr_wdata = 8'h3C;
    #1;
    chk("t6_ldr_gnt", ldr_gnt, 1'b1);
    chk("t6_ram_we", ram_we, 1'b1);
    cyc();
    ldr_req = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
    #1;
    chk("t6_cpu_gnt", cpu_gnt, 1'b1);
    chk("t6_write_no_rvalid", ldr_rvalid, 1'b0);
    cyc();
    cpu_req = 0;
    chk("t6_cpu_rvalid", cpu_rvalid, 1'b1);
    chk8("t6_cpu_rdata", cpu_rdata, 8'h3C);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
